// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the multdiv issue controller: FSM state encoding,
// the rstatus register index and the exception codes written to it.
package multdiv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [4:0]  RSTATUS_REG = 5'd30;
  localparam logic [31:0] RS_MULT_OVF = 32'd4;
  localparam logic [31:0] RS_DIV_ZERO = 32'd5;
  localparam logic [31:0] RS_TIMEOUT  = 32'd6;

endpackage

// File: rtl/mdc_timeout_counter.sv
// Loadable up-counter with a terminal flag, used as the WAIT watchdog.
// term is high while the count equals LIMIT-1, i.e. during the LIMIT-th
// enabled cycle after a load. LIMIT must be at least 1.
module mdc_timeout_counter #(
  parameter int unsigned LIMIT = 40
) (
  input  logic clock,
  input  logic clrn,
  input  logic load,
  input  logic en,
  output logic term
);

  localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [W-1:0] count;

  assign term = (count == W'(LIMIT - 1));

  // Clear on load, otherwise count enabled cycles and hold at the terminal value.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !term) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Execute-stage initiator for the iterative multdiv unit. Latches the
// operands of a mult/div, pulses the matching start for one cycle, stalls
// the pipeline until the unit reports ready, then issues one writeback
// (to rd, or to rstatus r30 with an exception code).
//
// Handshake: a start is taken only in IDLE when ex_is_mult|ex_is_div is
// high; stall stays high from that cycle until DONE, so the instruction is
// held in execute. md_resultRDY is only honoured from the second WAIT cycle
// on, which masks a ready left over from an earlier operation.
//
// Optional feature: define MULTDIV_TIMEOUT_EN to add a WAIT watchdog that
// forces DONE with rstatus code 6 after TIMEOUT_CYCLES WAIT cycles.
module multdiv_issue_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic        clock,
  input  logic        clrn,
  input  logic        ex_is_mult,
  input  logic        ex_is_div,
  input  logic [31:0] ex_operandA,
  input  logic [31:0] ex_operandB,
  input  logic [4:0]  ex_rd,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  state_t     state;
  logic       op_mult;
  logic       blank;
  logic [4:0] rd_q;
  logic       start;
  logic       ready;
  logic       timeout;

  assign start = ex_is_mult | ex_is_div;
  assign ready = md_resultRDY & ~blank;

  // Held low during reset so every output reads 0 while clrn is asserted.
  assign stall = clrn & (((state == ST_IDLE) & start) |
                         (state == ST_ISSUE) |
                         (state == ST_WAIT));

`ifdef MULTDIV_TIMEOUT_EN
  logic tmo_term;

  mdc_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock (clock),
    .clrn  (clrn),
    .load  (state == ST_ISSUE),
    .en    (state == ST_WAIT),
    .term  (tmo_term)
  );

  assign timeout = (state == ST_WAIT) & tmo_term;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES[0];
  assign timeout = 1'b0;
`endif

  // Control FSM with registered start pulses, operand latches and writeback.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state        <= ST_IDLE;
      op_mult      <= 1'b0;
      blank        <= 1'b0;
      rd_q         <= '0;
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      md_operandA  <= '0;
      md_operandB  <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
    end else begin
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            md_operandA  <= ex_operandA;
            md_operandB  <= ex_operandB;
            rd_q         <= ex_rd;
            op_mult      <= ex_is_mult;
            md_ctrl_MULT <= ex_is_mult;
            md_ctrl_DIV  <= ~ex_is_mult;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          blank <= 1'b1;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          blank <= 1'b0;
          if (ready) begin
            if (md_exception) begin
              wb_valid <= 1'b1;
              wb_rd    <= RSTATUS_REG;
              wb_data  <= op_mult ? RS_MULT_OVF : RS_DIV_ZERO;
            end else begin
              wb_valid <= (rd_q != 5'd0);
              wb_rd    <= rd_q;
              wb_data  <= md_result;
            end
            state <= ST_DONE;
          end else if (timeout) begin
            wb_valid <= 1'b1;
            wb_rd    <= RSTATUS_REG;
            wb_data  <= RS_TIMEOUT;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          wb_valid <= 1'b0;
          wb_rd    <= '0;
          wb_data  <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
